bram_sweep_engine: RTL

- Sequencer that sits directly in front of a simple-dual-port BRAM: one write port (waddr/din), one registered read port (raddr → dout).
- Two modes. FILL writes a deterministic pattern into every word. SCAN reads every word, folds the words into a 64-bit signature and compares it against an expected value.
- Used to check that bitstream memory re-initialisation landed, and to load known contents before a readback.
- During SCAN and IDLE, the engine writes back the data it just read, so an array that writes on every clock keeps its contents.

---
 rtl/bram_sweep_pkg.sv | 31 +++
 rtl/bram_sweep_engine_if.sv | 28 ++
 rtl/bram_sweep_sig.sv | 67 ++++++
 rtl/bram_sweep_engine.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/bram_sweep_pkg.sv
// rtl/bram_sweep_pkg.sv - shared types and datapath helpers for the BRAM sweep engine
// Signature and fill helpers operate on the default 64-bit word width.
package bram_sweep_pkg;

  localparam int SIG_W = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic {
    SCAN_M = 1'b0,
    FILL_M = 1'b1
  } mode_t;

  // Rotate-left-by-one then fold in the new word.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                input logic [SIG_W-1:0] data);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ data;
  endfunction

  function automatic logic [SIG_W-1:0] fill_word(input logic [SIG_W-1:0] seed,
                                                 input logic [SIG_W-1:0] addr);
    return seed + addr;
  endfunction

endpackage

// File: rtl/bram_sweep_engine_if.sv
// rtl/bram_sweep_engine_if.sv - simple-dual-port BRAM bus between sweep engine and memory
// master = engine side, slave = memory side.
interface bram_sweep_engine_if #(
  parameter int WID_MEM = 64,
  parameter int ADDR_W  = 9
);
  logic [ADDR_W-1:0]  mem_raddr;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [WID_MEM-1:0] mem_din;
  logic               mem_we;
  logic [WID_MEM-1:0] mem_dout;

  modport master (
    output mem_raddr,
    output mem_waddr,
    output mem_din,
    output mem_we,
    input  mem_dout
  );

  modport slave (
    input  mem_raddr,
    input  mem_waddr,
    input  mem_din,
    input  mem_we,
    output mem_dout
  );
endinterface

// File: rtl/bram_sweep_sig.sv
// rtl/bram_sweep_sig.sv - read-latency valid/address pipe and signature accumulator
// The delayed address doubles as the write-back address for always-write arrays.
module bram_sweep_sig
  import bram_sweep_pkg::*;
#(
  parameter int WID_MEM = 64,
  parameter int ADDR_W  = 9,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WID_MEM-1:0] seed,
  input  logic               issue_vld,
  input  logic [ADDR_W-1:0]  issue_addr,
  input  logic [WID_MEM-1:0] rd_data,
  output logic [ADDR_W-1:0]  wb_addr,
  output logic               word_vld,
  output logic [WID_MEM-1:0] sig,
  output logic [WID_MEM-1:0] sig_next
);

  logic [RD_LAT-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0]  addr_q [RD_LAT];
  logic [ADDR_W-1:0]  addr_d [RD_LAT];
  logic [WID_MEM-1:0] sig_q, sig_d;

  always_comb begin
    vld_d     = vld_q;
    addr_d    = addr_q;
    vld_d[0]  = issue_vld;
    addr_d[0] = issue_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  assign word_vld = vld_q[RD_LAT-1];
  assign wb_addr  = addr_q[RD_LAT-1];
  assign sig      = sig_q;

  always_comb begin
    sig_next = sig_q;
    if (word_vld) begin
      sig_next = sig_step(sig_q, rd_data);
    end
    sig_d = load ? seed : sig_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      sig_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      sig_q <= sig_d;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= addr_d[i];
      end
    end
  end

endmodule

// File: rtl/bram_sweep_engine.sv
// rtl/bram_sweep_engine.sv - FILL/SCAN sequencer in front of a simple-dual-port BRAM
// Outside FILL it writes back each word it read so always-write arrays keep their contents.
module bram_sweep_engine
  import bram_sweep_pkg::*;
#(
  parameter int WID_MEM   = 64,
  parameter int DEPTH_MEM = 512,
  parameter int ADDR_W    = 9,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WID_MEM-1:0]   seed,
  input  logic [WID_MEM-1:0]   expected_sig,
  bram_sweep_engine_if.master  mem,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [WID_MEM-1:0]   signature
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH_MEM - 1);
  localparam int                DRN_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(RD_LAT - 1);

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [WID_MEM-1:0] seed_q, seed_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [ADDR_W-1:0]  fill_q, fill_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               pass_q, pass_d;
  logic [WID_MEM-1:0] sig_out_q, sig_out_d;

  logic               accept;
  logic [ADDR_W-1:0]  wb_addr;
  logic               word_vld;
  logic [WID_MEM-1:0] sig_cur;
  logic [WID_MEM-1:0] sig_next;

  assign accept = (state_q == IDLE) && start;

  bram_sweep_sig #(
    .WID_MEM (WID_MEM),
    .ADDR_W  (ADDR_W),
    .RD_LAT  (RD_LAT)
  ) u_sig (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .seed       (seed),
    .issue_vld  (state_q == SCAN),
    .issue_addr (raddr_q),
    .rd_data    (mem.mem_dout),
    .wb_addr    (wb_addr),
    .word_vld   (word_vld),
    .sig        (sig_cur),
    .sig_next   (sig_next)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    raddr_d   = raddr_q;
    fill_d    = fill_q;
    drain_d   = drain_q;
    pass_d    = pass_q;
    sig_out_d = sig_out_q;

    case (state_q)
      IDLE: begin
        raddr_d = '0;
        if (start) begin
          mode_d    = mode_t'(mode);
          seed_d    = seed;
          pass_d    = 1'b0;
          sig_out_d = '0;
          fill_d    = '0;
          state_d   = mode ? FILL : SCAN;
        end
      end
      SCAN: begin
        if (raddr_q == ADDR_LAST) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          raddr_d = raddr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      FILL: begin
        if (fill_q == ADDR_LAST) begin
          state_d = DONE;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      DONE: begin
        raddr_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // sig_next already includes the word landing on the DRAIN exit edge.
    if ((state_d == DONE) && (state_q != DONE)) begin
      if (mode_q == FILL_M) begin
        pass_d    = 1'b1;
        sig_out_d = '0;
      end else begin
        pass_d    = (sig_next == expected_sig);
        sig_out_d = sig_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= SCAN_M;
      seed_q    <= '0;
      raddr_q   <= '0;
      fill_q    <= '0;
      drain_q   <= '0;
      pass_q    <= 1'b0;
      sig_out_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      seed_q    <= seed_d;
      raddr_q   <= raddr_d;
      fill_q    <= fill_d;
      drain_q   <= drain_d;
      pass_q    <= pass_d;
      sig_out_q <= sig_out_d;
    end
  end

  // FILL leaves raddr at 0 so the write-back after FILL re-writes word 0 with fresh data.
  assign mem.mem_raddr = raddr_q;
  assign mem.mem_we    = (state_q == FILL);
  assign mem.mem_waddr = (state_q == FILL) ? fill_q : wb_addr;
  assign mem.mem_din   = (state_q == FILL)
                         ? fill_word(seed_q, {{(WID_MEM-ADDR_W){1'b0}}, fill_q})
                         : mem.mem_dout;

  assign busy      = (state_q == SCAN) || (state_q == DRAIN) || (state_q == FILL);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_out_q;

endmodule
